// File: rtl/elastic_buffer_pkg.sv
// Shared parameters and state encoding for the elastic buffer / fork / join family.
// The state enum doubles as the occupancy count so benches can scoreboard with it.
package elastic_buffer_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    EB_EMPTY = 2'd0,
    EB_HALF  = 2'd1,
    EB_FULL  = 2'd2
  } eb_state_t;

endpackage

// File: rtl/elastic_buffer.sv
// Two-slot elastic buffer on a valid/stop handshake. Data, valid and stop are all
// driven straight from registers, which breaks the combinational stop chain upstream.
module elastic_buffer
  import elastic_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic                  valid_input,
  output logic                  stop_input,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  valid_output,
  input  logic                  stop_output,
  output logic [1:0]            occupancy
);

  eb_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_aux;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = valid_input & ~stop_input;
  assign w_out_xfer = valid_output & ~stop_output;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EB_EMPTY;
      r_main  <= '0;
      r_aux   <= '0;
    end else begin
      case (r_state)
        EB_EMPTY: begin
          if (w_in_xfer) begin
            r_main  <= input_data;
            r_state <= EB_HALF;
          end
        end
        EB_HALF: begin
          // Pass-through keeps the buffer at one token and sustains full rate.
          if (w_in_xfer && w_out_xfer) begin
            r_main <= input_data;
          end else if (w_in_xfer) begin
            r_aux   <= input_data;
            r_state <= EB_FULL;
          end else if (w_out_xfer) begin
            r_state <= EB_EMPTY;
          end
        end
        EB_FULL: begin
          // Input is refused here, so only the drain side can move.
          if (w_out_xfer) begin
            r_main  <= r_aux;
            r_state <= EB_HALF;
          end
        end
        default: r_state <= EB_EMPTY;
      endcase
    end
  end

  assign valid_output = (r_state == EB_HALF) || (r_state == EB_FULL);
  assign stop_input   = (r_state == EB_FULL);
  assign output_data  = r_main;
  assign occupancy    = r_state;

endmodule

// File: tb/tb_elastic_buffer.sv
// Bench for elastic_buffer: a queue model checked every cycle, directed scenarios
// with literal expectations, then randomized valid/stop traffic.
module tb_elastic_buffer;
  import elastic_buffer_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [DATA_WIDTH-1:0] input_data = '0;
  logic                  valid_input = 1'b0;
  logic                  stop_input;
  logic [DATA_WIDTH-1:0] output_data;
  logic                  valid_output;
  logic                  stop_output = 1'b0;
  logic [1:0]            occupancy;

  int errors = 0;
  int checks = 0;

  logic [DATA_WIDTH-1:0] mq[$];
  bit model_ok = 1'b0;

  always #5 clk = ~clk;

  elastic_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .input_data   (input_data),
    .valid_input  (valid_input),
    .stop_input   (stop_input),
    .output_data  (output_data),
    .valid_output (valid_output),
    .stop_output  (stop_output),
    .occupancy    (occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a two-entry queue; refusal is decided by the count held before the edge.
  always @(posedge clk) begin
    bit in_x;
    bit out_x;
    if (reset) begin
      mq.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      in_x  = valid_input && (mq.size() < 2);
      out_x = (mq.size() > 0) && !stop_output;
      if (out_x) void'(mq.pop_front());
      if (in_x) mq.push_back(input_data);
    end
  end

  // Per-cycle comparison against the model once both sides have settled.
  always @(posedge clk) begin
    #2;
    if (model_ok) begin
      chk("m_occ", 32'(occupancy), 32'(mq.size()));
      chk("m_valid", 32'(valid_output), 32'(mq.size() > 0));
      chk("m_stop", 32'(stop_input), 32'(mq.size() == 2));
      if (mq.size() > 0) chk("m_data", output_data, mq[0]);
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic so);
    valid_input = v;
    input_data  = d;
    stop_output = so;
  endtask

  task automatic expect_state(input string tag, input logic [1:0] occ, input logic vo,
                              input logic si, input logic [31:0] data, input bit chk_data);
    chk({tag, "_occ"}, 32'(occupancy), 32'(occ));
    chk({tag, "_valid"}, 32'(valid_output), 32'(vo));
    chk({tag, "_stop"}, 32'(stop_input), 32'(si));
    if (chk_data) chk({tag, "_data"}, output_data, data);
  endtask

  initial begin
    logic [31:0] stream [4];
    stream[0] = 32'h11; stream[1] = 32'h22; stream[2] = 32'h33; stream[3] = 32'h44;

    // Reset then idle, with stop_output toggling.
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_state("rst", 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'hDEAD, i[0]);
      @(negedge clk);
    end
    expect_state("idle", 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Streaming at full rate.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, stream[i], 1'b0);
      @(negedge clk);
      expect_state("strm", 2'd1, 1'b1, 1'b0, stream[i], 1'b1);
    end
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    expect_state("strm_end", 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Backpressure fill: A1, A2 accepted, A3 held upstream.
    drive(1'b1, 32'hA1, 1'b1);
    @(negedge clk);
    expect_state("bp1", 2'd1, 1'b1, 1'b0, 32'hA1, 1'b1);
    drive(1'b1, 32'hA2, 1'b1);
    @(negedge clk);
    expect_state("bp2", 2'd2, 1'b1, 1'b1, 32'hA1, 1'b1);
    drive(1'b1, 32'hA3, 1'b1);
    @(negedge clk);
    expect_state("bp_hold", 2'd2, 1'b1, 1'b1, 32'hA1, 1'b1);

    // One-cycle drain from FULL: stop_input is still 1 during this cycle.
    drive(1'b1, 32'hA3, 1'b0);
    @(negedge clk);
    expect_state("drain", 2'd1, 1'b1, 1'b0, 32'hA2, 1'b1);
    drive(1'b1, 32'hA3, 1'b1);
    @(negedge clk);
    expect_state("a3_in", 2'd2, 1'b1, 1'b1, 32'hA2, 1'b1);
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    expect_state("a3_out", 2'd1, 1'b1, 1'b0, 32'hA3, 1'b1);
    @(negedge clk);
    expect_state("bp_empty", 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Reset while FULL discards B1/B2.
    drive(1'b1, 32'hB1, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'hB2, 1'b1);
    @(negedge clk);
    expect_state("b_full", 2'd2, 1'b1, 1'b1, 32'hB1, 1'b1);
    drive(1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_state("mid_rst", 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_ghost_valid", 32'(valid_output), 32'h0);
    end

    // Randomized traffic, 50% valid and 50% stop densities.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      @(negedge clk);
    end

    // Drain whatever remains.
    drive(1'b0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    expect_state("final", 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
